mac_pe_te: RTL and testbench

//  Parametrised weight-stationary systolic MAC processing element with timing-error drop (TE-Drop) handling.

---
 rtl/mac_te_pkg.sv | 16 +
 rtl/te_err_counter.sv | 34 +++
 rtl/mac_pe_te.sv | 128 ++++++++++++
 tb/tb_mac_pe_te.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_te_pkg.sv
// Shared definitions for the TE-Drop MAC processing element and the array
// top that instantiates it.
//   TE_OFF / TE_DROP / TE_CORRECT : encodings of te_mode_i (2'b11 behaves as OFF)
//   acc_w_ok()                    : elaboration-time width check; the partial
//                                   sum must hold a full product plus one carry bit
package mac_te_pkg;

  localparam logic [1:0] TE_OFF     = 2'b00;
  localparam logic [1:0] TE_DROP    = 2'b01;
  localparam logic [1:0] TE_CORRECT = 2'b10;

  function automatic bit acc_w_ok(input int acc_w, input int act_w, input int wgt_w);
    return acc_w >= act_w + wgt_w + 1;
  endfunction

endpackage

// File: rtl/te_err_counter.sv
// Saturating timing-error event counter.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous reset, active low
//   i_en     gates increments only; clear works regardless of enable
//   i_clr    clear to zero, priority over increment
//   i_inc    count one event this cycle
//   o_cnt    current count, sticks at all-ones
module te_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_pe_te.sv
// Weight-stationary systolic MAC processing element with timing-error drop
// handling. The incoming partial sum is compared with its late shadow sample;
// on a mismatch the operation is either dropped (shadow forwarded as-is) or
// corrected (shadow used as the accumulate base), depending on te_mode_i.
// Ports:
//   clk, rst_n, en        clock, sync active-low reset, pipeline advance
//   wgt_load_i, wgt_i     stationary weight load
//   act_i, act_valid_i    activation in (left), operation qualifier
//   psum_i, psum_shadow_i partial sum in (top) and its shadow sample
//   te_mode_i             OFF / DROP / CORRECT (11 = OFF)
//   te_cnt_clr_i          clear the mismatch counter
//   act_o, act_valid_o    activation out (right), 1-cycle delay
//   psum_o, psum_valid_o  partial sum out (bottom), 2-cycle latency
//   te_flag_o             psum_o was produced from a detected mismatch
//   te_cnt_o              saturating mismatch count
module mac_pe_te
  import mac_te_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wgt_load_i,
  input  logic [WGT_W-1:0] wgt_i,
  input  logic [ACT_W-1:0] act_i,
  input  logic             act_valid_i,
  input  logic [ACC_W-1:0] psum_i,
  input  logic [ACC_W-1:0] psum_shadow_i,
  input  logic [1:0]       te_mode_i,
  input  logic             te_cnt_clr_i,
  output logic [ACT_W-1:0] act_o,
  output logic             act_valid_o,
  output logic [ACC_W-1:0] psum_o,
  output logic             psum_valid_o,
  output logic             te_flag_o,
  output logic [CNT_W-1:0] te_cnt_o
);

  localparam int PROD_W = ACT_W + WGT_W;

  if (!acc_w_ok(ACC_W, ACT_W, WGT_W)) begin : g_acc_w_chk
    $error("mac_pe_te: ACC_W must be at least ACT_W+WGT_W+1");
  end

  // Add with one carry bit; clamp to all-ones on carry-out when SAT is set.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    if (SAT && s[ACC_W]) return {ACC_W{1'b1}};
    return s[ACC_W-1:0];
  endfunction

  logic [WGT_W-1:0]  r_wgt;
  logic [ACT_W-1:0]  r_act;
  logic              r_act_vld;
  logic [PROD_W-1:0] r_prod_p1;
  logic [ACC_W-1:0]  r_base_p1;
  logic              r_vld_p1;
  logic              r_te_p1;
  logic [ACC_W-1:0]  r_psum_p2;
  logic              r_vld_p2;
  logic              r_te_p2;

  logic              w_mm;
  logic              w_te_on;
  logic              w_te;
  logic [ACC_W-1:0]  w_base;
  logic [PROD_W-1:0] w_prod;

  // w_mm already includes act_valid_i, so bubbles never raise te or count.
  assign w_mm    = act_valid_i && (psum_i != psum_shadow_i);
  assign w_te_on = (te_mode_i == TE_DROP) || (te_mode_i == TE_CORRECT);
  assign w_te    = w_mm && w_te_on;
  assign w_base  = w_te ? psum_shadow_i : psum_i;
  assign w_prod  = (w_mm && (te_mode_i == TE_DROP)) ? '0
                 : PROD_W'(act_i) * PROD_W'(r_wgt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wgt     <= '0;
      r_act     <= '0;
      r_act_vld <= 1'b0;
      r_prod_p1 <= '0;
      r_base_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_te_p1   <= 1'b0;
      r_psum_p2 <= '0;
      r_vld_p2  <= 1'b0;
      r_te_p2   <= 1'b0;
    end else if (en) begin
      // w_prod reads r_wgt before this write, so a same-cycle op sees the old weight.
      if (wgt_load_i) r_wgt <= wgt_i;
      r_act     <= act_i;
      r_act_vld <= act_valid_i;
      // ---- stage 1: product and selected base ----
      r_prod_p1 <= w_prod;
      r_base_p1 <= w_base;
      r_vld_p1  <= act_valid_i;
      r_te_p1   <= w_te;
      // ---- stage 2: accumulate ----
      r_psum_p2 <= acc_add(r_base_p1, r_prod_p1);
      r_vld_p2  <= r_vld_p1;
      r_te_p2   <= r_te_p1;
    end
  end

  te_err_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_clr   (te_cnt_clr_i),
    .i_inc   (w_mm),
    .o_cnt   (te_cnt_o)
  );

  assign act_o        = r_act;
  assign act_valid_o  = r_act_vld;
  assign psum_o       = r_psum_p2;
  assign psum_valid_o = r_vld_p2;
  assign te_flag_o    = r_te_p2;

endmodule

// File: tb/tb_mac_pe_te.sv
module tb_mac_pe_te;
  import mac_te_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, wgt_load, act_valid, clr;
  logic [7:0]  wgt, act;
  logic [23:0] psum, shadow;
  logic [1:0]  mode;

  logic [7:0]  d_act_o, s_act_o, c_act_o;
  logic        d_av, s_av, c_av;
  logic [23:0] d_psum, s_psum, c_psum;
  logic        d_pv, s_pv, c_pv;
  logic        d_te, s_te, c_te;
  logic [15:0] d_cnt, s_cnt;
  logic [1:0]  c_cnt;

  mac_pe_te u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wgt_load_i(wgt_load), .wgt_i(wgt),
    .act_i(act), .act_valid_i(act_valid), .psum_i(psum), .psum_shadow_i(shadow),
    .te_mode_i(mode), .te_cnt_clr_i(clr), .act_o(d_act_o), .act_valid_o(d_av),
    .psum_o(d_psum), .psum_valid_o(d_pv), .te_flag_o(d_te), .te_cnt_o(d_cnt));

  mac_pe_te #(.SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .wgt_load_i(wgt_load), .wgt_i(wgt),
    .act_i(act), .act_valid_i(act_valid), .psum_i(psum), .psum_shadow_i(shadow),
    .te_mode_i(mode), .te_cnt_clr_i(clr), .act_o(s_act_o), .act_valid_o(s_av),
    .psum_o(s_psum), .psum_valid_o(s_pv), .te_flag_o(s_te), .te_cnt_o(s_cnt));

  mac_pe_te #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(en), .wgt_load_i(wgt_load), .wgt_i(wgt),
    .act_i(act), .act_valid_i(act_valid), .psum_i(psum), .psum_shadow_i(shadow),
    .te_mode_i(mode), .te_cnt_clr_i(clr), .act_o(c_act_o), .act_valid_o(c_av),
    .psum_o(c_psum), .psum_valid_o(c_pv), .te_flag_o(c_te), .te_cnt_o(c_cnt));

  typedef struct {
    logic [23:0] wrap;
    logic [23:0] sat;
    logic        te;
    int unsigned t;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  bit          have_last = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  m_wgt = '0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;
  int unsigned adv_cnt = 0;
  logic        adv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count of enabled, non-reset edges; an op pushed at count t shows at t+2.
  always @(posedge clk) begin
    adv <= rst_n && en;
    if (rst_n && en) adv_cnt <= adv_cnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (adv && d_pv) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(d_pv), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", adv_cnt, e.t + 2);
        chk("psum", d_psum, e.wrap);
        chk("te_flag", d_te, e.te);
        chk("psum_sat", s_psum, e.sat);
        chk("valid_sat", s_pv, 1);
        chk("psum_c2", c_psum, e.wrap);
        chk("valid_c2", c_pv, 1);
        last = e;
        have_last = 1'b1;
      end
    end else if (adv && !d_pv) begin
      chk("bubble_te_flag", d_te, 0);
      if (sb.size() > 0 && sb[0].t + 2 == adv_cnt) begin
        chk("missing_valid", 0, 1);
        void'(sb.pop_front());
      end
    end else if (!adv && rst_n && d_pv && have_last) begin
      chk("stall_hold", d_psum, last.wrap);
    end
    if (!rst_n) begin
      sb.delete();
      have_last = 1'b0;
    end
  end

  // Apply model for the inputs currently driven, then take one clock edge.
  task automatic step();
    exp_t        e;
    logic        mm, te;
    logic [15:0] prod;
    logic [24:0] s;
    mm = act_valid && (psum != shadow);
    te = mm && (mode == TE_DROP || mode == TE_CORRECT);
    if (rst_n && en && act_valid) begin
      prod   = (mm && mode == TE_DROP) ? 16'd0 : act * m_wgt;
      s      = {1'b0, (te ? shadow : psum)} + {9'd0, prod};
      e.wrap = s[23:0];
      e.sat  = s[24] ? 24'hFFFFFF : s[23:0];
      e.te   = te;
      e.t    = adv_cnt;
      sb.push_back(e);
    end
    if (!rst_n || clr) begin
      m_cnt  = '0;
      m_cnt2 = '0;
    end else if (en && mm) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_cnt2 != 2'b11) m_cnt2++;
    end
    if (!rst_n) m_wgt = '0;
    else if (en && wgt_load) m_wgt = wgt;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ld, input logic [7:0] w, input logic v, input logic [7:0] a,
                     input logic [23:0] p, input logic [23:0] sh, input logic [1:0] md);
    wgt_load = ld; wgt = w; act_valid = v; act = a; psum = p; shadow = sh; mode = md;
    step();
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, d_cnt, m_cnt);
    chk({tag, "_cnt_sat"}, s_cnt, m_cnt);
    chk({tag, "_cnt2"}, c_cnt, m_cnt2);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, TE_OFF);
  endtask

  initial begin
    rst_n = 0; en = 1; clr = 0;
    wgt_load = 0; wgt = 0; act_valid = 0; act = 0; psum = 0; shadow = 0; mode = TE_OFF;
    step(); step();
    chk("rst_psum", d_psum, 0);
    chk("rst_pvalid", d_pv, 0);
    chk("rst_te_flag", d_te, 0);
    chk("rst_act", d_act_o, 0);
    chk("rst_avalid", d_av, 0);
    chk("rst_sat_out", {s_act_o, s_av, s_te, s_pv}, 0);
    chk("rst_c2_out", {c_act_o, c_av, c_te}, 0);
    chk_cnt("rst");
    rst_n = 1;

    drv(1, 8'd3, 0, 0, 0, 0, TE_OFF);
    drv(0, 0, 1, 8'd5, 24'd100, 24'd100, TE_OFF);
    chk("fwd_act", d_act_o, 5);
    chk("fwd_avalid", d_av, 1);
    drv(0, 0, 1, 8'd5, 24'd100, 24'd104, TE_DROP);
    chk_cnt("drop");
    drv(0, 0, 1, 8'd5, 24'd100, 24'd104, TE_CORRECT);
    drv(0, 0, 1, 8'd5, 24'd100, 24'd104, TE_OFF);
    drv(0, 0, 1, 8'd5, 24'd100, 24'd104, 2'b11);
    chk_cnt("modes");
    bubbles(2);

    drv(1, 8'd255, 0, 0, 0, 0, TE_OFF);
    drv(0, 0, 1, 8'd255, 24'hFFFFF6, 24'hFFFFF6, TE_OFF);
    bubbles(2);

    drv(1, 8'd3, 0, 0, 0, 0, TE_OFF);
    drv(1, 8'd7, 1, 8'd2, 24'd1000, 24'd1000, TE_OFF);
    drv(0, 0, 1, 8'd2, 24'd1000, 24'd1000, TE_OFF);
    drv(0, 0, 1, 8'd1, 24'd10, 24'd10, TE_OFF);
    en = 0;
    for (int i = 0; i < 3; i++) drv(1, 8'd99, 1, 8'd9, 24'd50, 24'd51, TE_DROP);
    chk_cnt("stall");
    en = 1;
    drv(0, 0, 1, 8'd4, 24'd20, 24'd20, TE_OFF);
    bubbles(3);

    clr = 1; drv(0, 0, 0, 0, 0, 0, TE_OFF); clr = 0;
    chk_cnt("clr");
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 8'd1, 24'(i), 24'(i + 1), TE_DROP);
    chk_cnt("sat5");
    clr = 1; drv(0, 0, 1, 8'd1, 24'd5, 24'd6, TE_DROP); clr = 0;
    chk_cnt("clr_mm");
    bubbles(2);

    drv(0, 0, 1, 8'd3, 24'd7, 24'd7, TE_OFF);
    drv(0, 0, 1, 8'd4, 24'd8, 24'd9, TE_CORRECT);
    rst_n = 0; drv(0, 0, 0, 0, 0, 0, TE_OFF);
    chk_cnt("rst_flight");
    rst_n = 1;
    bubbles(4);

    drv(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0, TE_OFF);
    for (int i = 0; i < 80; i++) begin
      logic [23:0] p;
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 19) == 0);
      p   = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 70000))
                                        : 24'($urandom);
      drv(($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom), 8'($urandom), p,
          ($urandom_range(0, 9) < 3) ? p ^ 24'(1 << $urandom_range(0, 23)) : p,
          2'($urandom));
      chk_cnt("rand");
    end
    en = 1; clr = 0;
    bubbles(4);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
